call_return_ctrl: RTL

Control block for the return-address stack, on its read/consume side. It sits between decode and the PC-select logic:
- On a call, it drives the stack's push code together with the current PC.
- On a return, it drives the pop code, captures the popped address and issues a one-cycle PC redirect.
- It tracks stack depth, so a return with nothing on the stack falls back to a register-file target instead of reading garbage.

---
 rtl/call_return_ctrl_pkg.sv | 6 +
 rtl/call_return_ctrl_depth_counter.sv | 24 ++
 rtl/call_return_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/call_return_ctrl_pkg.sv
// call_return_ctrl_pkg: shared FSM encoding and stack constants for the return-address stack controller.
package call_return_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_WAIT, S_REDIR} state_t;
  localparam int RAS_DEPTH = 4;
  localparam logic [4:0] RAS_MARK = 5'b11110;
endpackage

// File: rtl/call_return_ctrl_depth_counter.sv
// depth_counter: saturating up/down counter over 0..DEPTH with full and empty flags.
module depth_counter #(
  parameter int DEPTH = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);
  localparam logic [W-1:0] MAX = W'(DEPTH);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (i_inc && !o_full) r_count <= r_count + 1'b1;
    else if (i_dec && !o_empty) r_count <= r_count - 1'b1;
  end
  assign o_count = r_count;
  assign o_full  = r_count == MAX;
  assign o_empty = r_count == '0;
endmodule

// File: rtl/call_return_ctrl.sv
// call_return_ctrl: drives return-address stack push/pop codes and issues the PC redirect on returns.
module call_return_ctrl
  import call_return_ctrl_pkg::*;
#(
  parameter int N = 32,
  parameter int DEPTH = RAS_DEPTH,
  parameter logic [4:0] MARK = RAS_MARK
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Call,
  input  logic         Ret,
  input  logic [N-1:0] PC,
  input  logic [N-1:0] FallbackAddr,
  input  logic [N-1:0] StackData,
  output logic [4:0]   Push,
  output logic [4:0]   Pop,
  output logic [N-1:0] StackIn,
  output logic         Redirect,
  output logic [N-1:0] RedirectAddr,
  output logic         Stall,
  output logic [2:0]   Depth,
  output logic         Underflow,
  output logic         Overflow
);
  state_t       r_state;
  logic [4:0]   r_push, r_pop;
  logic [N-1:0] r_stack_in, r_redirect_addr;
  logic         r_redirect, r_stall, r_underflow, r_overflow, r_from_pop;
  logic         w_full, w_empty, w_inc, w_dec;
  logic [2:0]   w_depth;
  // Depth moves on the edge that leaves PUSH, or REDIR when it was reached through a real pop.
  assign w_inc = r_state == S_PUSH;
  assign w_dec = r_state == S_REDIR && r_from_pop;
  depth_counter #(.DEPTH(DEPTH), .W(3)) u_depth (
    .clk(CLK), .rst_n(RST), .i_inc(w_inc), .i_dec(w_dec),
    .o_count(w_depth), .o_full(w_full), .o_empty(w_empty)
  );
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state         <= S_IDLE;
      r_push          <= '0;
      r_pop           <= '0;
      r_stack_in      <= '0;
      r_redirect      <= 1'b0;
      r_redirect_addr <= '0;
      r_stall         <= 1'b0;
      r_underflow     <= 1'b0;
      r_overflow      <= 1'b0;
      r_from_pop      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Call) begin
            r_state    <= S_PUSH;
            r_push     <= MARK;
            r_stack_in <= PC;
            r_stall    <= 1'b1;
            r_overflow <= w_full;
          end else if (Ret && !w_empty) begin
            r_state    <= S_POP;
            r_pop      <= MARK;
            r_stall    <= 1'b1;
            r_from_pop <= 1'b1;
          end else if (Ret) begin
            r_state         <= S_REDIR;
            r_redirect      <= 1'b1;
            r_redirect_addr <= FallbackAddr;
            r_underflow     <= 1'b1;
            r_stall         <= 1'b1;
            r_from_pop      <= 1'b0;
          end
        end
        S_PUSH: begin
          r_state    <= S_IDLE;
          r_push     <= '0;
          r_stack_in <= '0;
          r_stall    <= 1'b0;
          r_overflow <= 1'b0;
        end
        S_POP: begin
          r_state <= S_WAIT;
          r_pop   <= '0;
        end
        S_WAIT: begin
          r_state         <= S_REDIR;
          r_redirect      <= 1'b1;
          r_redirect_addr <= StackData;
        end
        S_REDIR: begin
          r_state     <= S_IDLE;
          r_redirect  <= 1'b0;
          r_underflow <= 1'b0;
          r_stall     <= 1'b0;
          r_from_pop  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign Push         = r_push;
  assign Pop          = r_pop;
  assign StackIn      = r_stack_in;
  assign Redirect     = r_redirect;
  assign RedirectAddr = r_redirect_addr;
  assign Stall        = r_stall;
  assign Depth        = w_depth;
  assign Underflow    = r_underflow;
  assign Overflow     = r_overflow;
endmodule
